// File: rtl/vc_input_port_pkg.sv
// Shared definitions for the virtual-channel input port: default sizing
// and the index / flit types used by the port and its bench.
package vc_input_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_VC     = 2;
    localparam int DEF_VC_DEPTH   = 2;
    localparam int DEF_CNT_WIDTH  = 16;

    // Phase counter and VC index share one type: the phase is the read VC.
    typedef logic [$clog2(DEF_NUM_VC)-1:0] vc_idx_t;
    typedef logic [DEF_DATA_WIDTH-1:0]     flit_t;

endpackage

// File: rtl/vc_input_port_if.sv
// Upstream and switch-side signals of one virtual-channel input port.
// master: the environment (upstream sender + switch); slave: the port.
interface vc_input_port_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_VC     = 2,
    parameter int CNT_WIDTH  = 16
);
    localparam int VC_W = $clog2(NUM_VC);

    logic                  sendI;
    logic [DATA_WIDTH-1:0] dataI;
    logic                  receiveI;
    logic                  sig_channel_clean;
    logic                  sig_req_channel;
    logic [DATA_WIDTH-1:0] inner_dataO;
    logic [VC_W-1:0]       req_vc;
    logic                  polarity;
    logic [CNT_WIDTH-1:0]  drop_cnt;

    modport master (
        output sendI, dataI, sig_channel_clean,
        input  receiveI, sig_req_channel, inner_dataO, req_vc, polarity, drop_cnt
    );

    modport slave (
        input  sendI, dataI, sig_channel_clean,
        output receiveI, sig_req_channel, inner_dataO, req_vc, polarity, drop_cnt
    );

endinterface

// File: rtl/vc_input_port_fifo.sv
// Single virtual-channel buffer: synchronous FIFO with occupancy counter.
// dout is forced to zero while empty so the port can expose it directly.
module vc_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    // A depth-1 FIFO still needs a one-bit pointer; it simply never moves.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_fire;
    logic             rd_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointers and occupancy from the accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_fire) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_fire) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wr_fire, rd_fire})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; reset empties the buffer without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Flit storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/vc_input_port.sv
// Time-multiplexed virtual-channel input port.
// A free-running phase counter selects the read VC (phase) and the write VC
// (phase+1 mod NUM_VC), so a push and a pop never target the same buffer.
// Optional build macro VC_INPUT_PORT_DROP_CNT_EN enables a saturating count
// of flits dropped because the write VC was full; without it drop_cnt is 0.
module vc_input_port
    import vc_input_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_VC     = DEF_NUM_VC,
    parameter int VC_DEPTH   = DEF_VC_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    vc_input_port_if.slave  port_if
);
    localparam int VC_W = $clog2(NUM_VC);

    logic [VC_W-1:0]       phase_q, phase_d;
    logic [VC_W-1:0]       rd_vc;
    logic [VC_W-1:0]       wr_vc;
    logic                  receive;
    logic                  push;
    logic                  pop;
    logic [NUM_VC-1:0]     vc_wr_en;
    logic [NUM_VC-1:0]     vc_rd_en;
    logic [NUM_VC-1:0]     vc_full;
    logic [NUM_VC-1:0]     vc_empty;
    logic [DATA_WIDTH-1:0] vc_dout [NUM_VC];

    assign rd_vc   = phase_q;
    assign wr_vc   = (phase_q == VC_W'(NUM_VC - 1)) ? '0 : phase_q + VC_W'(1);
    assign phase_d = wr_vc;

    assign receive = !vc_full[wr_vc];
    assign push    = port_if.sendI && receive;
    assign pop     = port_if.sig_channel_clean && !vc_empty[rd_vc];

    // Phase counter: steps through the VCs once per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Route the accepted push to the write VC and the grant to the read VC.
    always_comb begin
        vc_wr_en         = '0;
        vc_rd_en         = '0;
        vc_wr_en[wr_vc]  = push;
        vc_rd_en[rd_vc]  = pop;
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_sync_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (VC_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr_en (vc_wr_en[g]),
            .rd_en (vc_rd_en[g]),
            .din   (port_if.dataI),
            .dout  (vc_dout[g]),
            .full  (vc_full[g]),
            .empty (vc_empty[g])
        );
    end

    assign port_if.receiveI        = receive;
    assign port_if.sig_req_channel = !vc_empty[rd_vc];
    assign port_if.inner_dataO     = vc_dout[rd_vc];
    assign port_if.req_vc          = phase_q;
    assign port_if.polarity        = phase_q[0];

`ifdef VC_INPUT_PORT_DROP_CNT_EN
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of flits offered while the write VC was full.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (port_if.sendI && !receive && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign port_if.drop_cnt = drop_cnt_q;
`else
    assign port_if.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_vc_input_port.sv
// Bench for vc_input_port: a 2-VC and a 4-VC instance share one stimulus
// stream; each is compared every cycle against a queue-based model.
module tb_vc_input_port;
    import vc_input_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int CW    = 16;
`ifdef VC_INPUT_PORT_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef logic [63:0] fq_t [$];

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    vc_input_port_if #(.DATA_WIDTH(DW), .NUM_VC(2), .CNT_WIDTH(CW)) if2 ();
    vc_input_port_if #(.DATA_WIDTH(DW), .NUM_VC(4), .CNT_WIDTH(CW)) if4 ();

    vc_input_port #(.DATA_WIDTH(DW), .NUM_VC(2), .VC_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .port_if (if2)
    );

    vc_input_port #(.DATA_WIDTH(DW), .NUM_VC(4), .VC_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .port_if (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    fq_t q2 [2];
    fq_t q4 [4];
    int  ph2, ph4, drop2, drop4;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_port(input string p, input int n, input int ph, input int drop,
                              input int sz_rd, input int sz_wr, input logic [63:0] head,
                              input logic rx, input logic rq, input logic [63:0] dat,
                              input logic [63:0] vc, input logic pol, input logic [63:0] dc);
        chk({p, "_receiveI"}, 64'(rx), 64'(sz_wr < DEPTH));
        chk({p, "_sig_req"}, 64'(rq), 64'(sz_rd != 0));
        chk({p, "_inner_data"}, dat, (sz_rd != 0) ? head : 64'h0);
        chk({p, "_req_vc"}, vc, 64'(ph));
        chk({p, "_polarity"}, 64'(pol), 64'(ph % 2));
        chk({p, "_drop_cnt"}, dc, 64'(drop));
        if (n == 0) chk({p, "_never"}, 64'(0), 64'(1));
    endtask

    task automatic model_edge(input bit s, input logic [63:0] d, input bit g, input bit r);
        int w;
        if (r) begin
            ph2 = 0; ph4 = 0; drop2 = 0; drop4 = 0;
            foreach (q2[i]) q2[i].delete();
            foreach (q4[i]) q4[i].delete();
            return;
        end
        w = (ph2 + 1) % 2;
        if (s) begin
            if (q2[w].size() < DEPTH) q2[w].push_back(d);
            else if (DROP_EN && drop2 < 65535) drop2++;
        end
        if (g && q2[ph2].size() != 0) void'(q2[ph2].pop_front());
        ph2 = (ph2 + 1) % 2;
        w = (ph4 + 1) % 4;
        if (s) begin
            if (q4[w].size() < DEPTH) q4[w].push_back(d);
            else if (DROP_EN && drop4 < 65535) drop4++;
        end
        if (g && q4[ph4].size() != 0) void'(q4[ph4].pop_front());
        ph4 = (ph4 + 1) % 4;
    endtask

    // tag: 0 none, 2 dut2 data, 4 dut4 data, 5 dut2 receiveI, 6 dut2 drop_cnt, 7 both sig_req
    task automatic step(input bit s, input logic [63:0] d, input bit g, input bit r,
                        input int tag, input logic [63:0] tval);
        logic [63:0] h2, h4;
        if2.sendI = s; if2.dataI = d; if2.sig_channel_clean = g;
        if4.sendI = s; if4.dataI = d; if4.sig_channel_clean = g;
        rst = r;
        #3;
        h2 = (q2[ph2].size() != 0) ? q2[ph2][0] : 64'h0;
        h4 = (q4[ph4].size() != 0) ? q4[ph4][0] : 64'h0;
        check_port("v2", 2, ph2, drop2, q2[ph2].size(), q2[(ph2 + 1) % 2].size(), h2,
                   if2.receiveI, if2.sig_req_channel, if2.inner_dataO, 64'(if2.req_vc),
                   if2.polarity, 64'(if2.drop_cnt));
        check_port("v4", 4, ph4, drop4, q4[ph4].size(), q4[(ph4 + 1) % 4].size(), h4,
                   if4.receiveI, if4.sig_req_channel, if4.inner_dataO, 64'(if4.req_vc),
                   if4.polarity, 64'(if4.drop_cnt));
        case (tag)
            2: chk("dir_v2_data", if2.inner_dataO, tval);
            4: chk("dir_v4_data", if4.inner_dataO, tval);
            5: chk("dir_v2_full", 64'(if2.receiveI), tval);
            6: chk("dir_v2_drop", 64'(if2.drop_cnt), tval);
            7: begin
                chk("dir_v2_req_clr", 64'(if2.sig_req_channel), tval);
                chk("dir_v4_req_clr", 64'(if4.sig_req_channel), tval);
            end
            default: ;
        endcase
        @(posedge clk);
        model_edge(s, d, g, r);
        #1;
    endtask

    initial begin
        bit          s, g, r;
        logic [63:0] d;
        rst = 1'b1;
        if2.sendI = 1'b0; if2.dataI = '0; if2.sig_channel_clean = 1'b0;
        if4.sendI = 1'b0; if4.dataI = '0; if4.sig_channel_clean = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 64'h0, 1'b0, 1'b1);
        #1;

        // Reset then idle: phases 0,1,0,1, nothing requested
        step(0, 64'h0, 0, 1, 0, 64'h0);
        for (int i = 0; i < 4; i++) step(0, 64'h0, 0, 0, 0, 64'h0);

        // Single flit, visible next cycle, then granted
        step(1, 64'hA5, 0, 0, 0, 64'h0);
        step(0, 64'h0, 1, 0, 2, 64'hA5);
        step(0, 64'h0, 0, 0, 0, 64'h0);
        step(0, 64'h0, 0, 0, 0, 64'h0);

        // Fill without grants: the third attempt at a VC is refused
        step(0, 64'h0, 0, 1, 0, 64'h0);
        step(1, 64'h101, 0, 0, 0, 64'h0);
        step(1, 64'h102, 0, 0, 0, 64'h0);
        step(1, 64'h103, 0, 0, 0, 64'h0);
        step(1, 64'h104, 0, 0, 0, 64'h0);
        step(1, 64'h105, 0, 0, 5, 64'h0);
        step(0, 64'h0, 0, 0, 6, 64'(DROP_EN));

        // 4-VC ordering: two flits into VC2, granted in FIFO order
        step(0, 64'h0, 0, 1, 0, 64'h0);
        step(0, 64'h0, 0, 0, 0, 64'h0);
        step(1, 64'h11, 0, 0, 0, 64'h0);
        step(0, 64'h0, 0, 0, 0, 64'h0);
        step(0, 64'h0, 0, 0, 0, 64'h0);
        step(0, 64'h0, 0, 0, 0, 64'h0);
        step(1, 64'h22, 0, 0, 0, 64'h0);
        step(0, 64'h0, 1, 0, 4, 64'h11);
        step(0, 64'h0, 0, 0, 0, 64'h0);
        step(0, 64'h0, 0, 0, 0, 64'h0);
        step(0, 64'h0, 0, 0, 0, 64'h0);
        step(0, 64'h0, 1, 0, 4, 64'h22);

        // Simultaneous push and grant
        step(1, 64'h31, 0, 0, 0, 64'h0);
        step(1, 64'h32, 1, 0, 0, 64'h0);
        step(1, 64'h33, 1, 0, 0, 64'h0);
        step(0, 64'h0, 1, 0, 0, 64'h0);

        // Reset with flits buffered, overriding a same-cycle push and grant
        step(0, 64'h0, 0, 1, 0, 64'h0);
        step(1, 64'h41, 0, 0, 0, 64'h0);
        step(1, 64'h42, 0, 0, 0, 64'h0);
        step(1, 64'h43, 1, 1, 0, 64'h0);
        step(0, 64'h0, 0, 0, 7, 64'h0);
        step(0, 64'h0, 0, 0, 7, 64'h0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 9) < 7);
            g = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 63) == 0);
            d = {$urandom, $urandom};
            step(s, d, g, r, 0, 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
